// File: rtl/ensemble_pkg.sv
// Shared constants and scheduler state encoding for the bin-ratio ensemble.
package ensemble_pkg;

  localparam int BIN_NUM     = 1024;
  localparam int CNT_W       = 20;
  localparam int ID_W        = 5;
  localparam int NUM_CLASSES = 18;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_WAIT   = 3'd2,
    S_TALLY  = 3'd3,
    S_ARGMAX = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ensemble_vote_tally.sv
// Vote counters plus sequential tally (one net per cycle) and argmax (one class per cycle).
// start_i kicks off NUM_NETS tally cycles then NUM_CLASSES argmax cycles; done_o marks the last.
module ensemble_vote_tally #(
  parameter int  NUM_NETS    = 20,
  parameter int  NUM_CLASSES = 18,
  parameter int  ID_W        = 5,
  localparam int VOTE_W      = $clog2(NUM_NETS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [NUM_NETS-1:0]      captured_i,
  input  logic [NUM_NETS*ID_W-1:0] winners_i,
  output logic                     tally_last_o,
  output logic                     done_o,
  output logic [ID_W-1:0]          class_o,
  output logic [VOTE_W-1:0]        votes_o
);

  typedef enum logic [1:0] {P_IDLE, P_TALLY, P_ARGMAX} phase_e;

  localparam int IDX_N = (NUM_NETS > NUM_CLASSES) ? NUM_NETS : NUM_CLASSES;
  localparam int IDX_W = $clog2(IDX_N);
  localparam logic [IDX_W-1:0]  LAST_NET = IDX_W'(NUM_NETS - 1);
  localparam logic [IDX_W-1:0]  LAST_CLS = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0]  ONE_I    = IDX_W'(1);
  localparam logic [VOTE_W-1:0] ONE_V    = VOTE_W'(1);
  localparam logic [ID_W:0]     CLS_LIM  = (ID_W+1)'(NUM_CLASSES);

  phase_e              phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VOTE_W-1:0]   vote_q [NUM_CLASSES];
  logic [VOTE_W-1:0]   vote_d [NUM_CLASSES];
  logic [ID_W-1:0]     best_q, best_d;
  logic [VOTE_W-1:0]   best_votes_q, best_votes_d;
  logic [ID_W-1:0]     win;

  always_comb begin
    phase_d      = phase_q;
    idx_d        = idx_q;
    vote_d       = vote_q;
    best_d       = best_q;
    best_votes_d = best_votes_q;
    tally_last_o = 1'b0;
    done_o       = 1'b0;
    win          = winners_i[int'(idx_q)*ID_W +: ID_W];

    case (phase_q)
      P_TALLY: begin
        // Out-of-range IDs are silently dropped.
        if (captured_i[idx_q] && ({1'b0, win} < CLS_LIM)) begin
          vote_d[win] = vote_q[win] + ONE_V;
        end
        if (idx_q == LAST_NET) begin
          tally_last_o = 1'b1;
          phase_d      = P_ARGMAX;
          idx_d        = '0;
        end else begin
          idx_d = idx_q + ONE_I;
        end
      end
      P_ARGMAX: begin
        // Strictly greater keeps the lowest class on ties.
        if (vote_q[idx_q] > best_votes_q) begin
          best_d       = ID_W'(idx_q);
          best_votes_d = vote_q[idx_q];
        end
        if (idx_q == LAST_CLS) begin
          done_o  = 1'b1;
          phase_d = P_IDLE;
        end else begin
          idx_d = idx_q + ONE_I;
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      phase_d      = P_IDLE;
      idx_d        = '0;
      best_d       = '0;
      best_votes_d = '0;
      for (int c = 0; c < NUM_CLASSES; c++) vote_d[c] = '0;
    end
    if (start_i) begin
      phase_d = P_TALLY;
      idx_d   = '0;
    end
  end

  // Final-cycle values include the last argmax comparison.
  assign class_o = best_d;
  assign votes_o = best_votes_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= P_IDLE;
      idx_q        <= '0;
      best_q       <= '0;
      best_votes_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) vote_q[c] <= '0;
    end else begin
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_votes_q <= best_votes_d;
      for (int c = 0; c < NUM_CLASSES; c++) vote_q[c] <= vote_d[c];
    end
  end

endmodule

// File: rtl/ensemble_infer_scheduler.sv
// Streams one spectrum to all nets, captures each net's first winner ID, then
// runs a sequential majority vote and reports the class to the host.
module ensemble_infer_scheduler
  import ensemble_pkg::*;
#(
  parameter int  NUM_NETS     = 20,
  parameter int  NUM_CLASSES  = ensemble_pkg::NUM_CLASSES,
  parameter int  BIN_NUM      = ensemble_pkg::BIN_NUM,
  parameter int  CNT_W        = ensemble_pkg::CNT_W,
  parameter int  ID_W         = ensemble_pkg::ID_W,
  parameter int  WAIT_TIMEOUT = 60000,
  localparam int VOTE_W       = $clog2(NUM_NETS + 1),
  localparam int ADDR_W       = $clog2(BIN_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  output logic                     sample_ack,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [CNT_W-1:0]         mem_rd_data,
  output logic [NUM_NETS-1:0]      net_trans_start,
  output logic [CNT_W-1:0]         net_bin_cnt,
  input  logic [NUM_NETS-1:0]      net_request_new_sample,
  input  logic [NUM_NETS-1:0]      net_infer_ready,
  input  logic [NUM_NETS*ID_W-1:0] net_winner_ID,
  output logic                     result_valid,
  output logic [ID_W-1:0]          result_class,
  output logic [VOTE_W-1:0]        result_votes,
  output logic                     result_timeout,
  output logic                     busy,
  output state_e                   dbg_state
);

  localparam int K_W = $clog2(BIN_NUM + 2);
  localparam logic [K_W-1:0] K_ONE   = K_W'(1);
  localparam logic [K_W-1:0] K_START = K_W'(2);
  localparam logic [K_W-1:0] K_RDEND = K_W'(BIN_NUM);
  localparam logic [K_W-1:0] K_LAST  = K_W'(BIN_NUM + 1);
  localparam logic [15:0]    W_LAST  = 16'(WAIT_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [15:0]              wait_q, wait_d;
  logic [NUM_NETS-1:0]      captured_q, captured_d;
  logic [NUM_NETS*ID_W-1:0] winner_q, winner_d;
  logic                     timeout_q, timeout_d;
  logic [CNT_W-1:0]         bin_cnt_q, bin_cnt_d;
  logic [ID_W-1:0]          res_class_q;
  logic [VOTE_W-1:0]        res_votes_q;
  logic                     res_to_q;
  logic                     enter_stream, tally_start, tally_last, tally_done;
  logic [ID_W-1:0]          final_class;
  logic [VOTE_W-1:0]        final_votes;

  // Handshake: the host holds sample_valid until the one-cycle sample_ack; a
  // sample is accepted only from IDLE with every net requesting a new sample.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    wait_d          = wait_q;
    captured_d      = captured_q;
    winner_d        = winner_q;
    timeout_d       = timeout_q;
    bin_cnt_d       = bin_cnt_q;
    enter_stream    = 1'b0;
    tally_start     = 1'b0;
    mem_rd_en       = 1'b0;
    mem_rd_addr     = '0;
    net_trans_start = '0;
    sample_ack      = 1'b0;
    result_valid    = 1'b0;

    if (state_q == S_STREAM || state_q == S_WAIT) begin
      for (int j = 0; j < NUM_NETS; j++) begin
        if (net_infer_ready[j] && !captured_q[j]) begin
          captured_d[j]                = 1'b1;
          winner_d[j*ID_W +: ID_W]     = net_winner_ID[j*ID_W +: ID_W];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sample_valid && (&net_request_new_sample)) begin
          state_d      = S_STREAM;
          enter_stream = 1'b1;
          k_d          = '0;
          wait_d       = '0;
          captured_d   = '0;
          timeout_d    = 1'b0;
        end
      end
      S_STREAM: begin
        if (k_q < K_RDEND) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = k_q[ADDR_W-1:0];
        end
        // Read data lags the address by one cycle, so bin i lands at k = i+2.
        if (k_q >= K_ONE && k_q <= K_RDEND) bin_cnt_d = mem_rd_data;
        if (k_q == K_START) net_trans_start = '1;
        if (k_q == K_LAST) begin
          sample_ack = 1'b1;
          state_d    = S_WAIT;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_WAIT: begin
        if (&captured_q) begin
          state_d     = S_TALLY;
          tally_start = 1'b1;
        end else if (wait_q == W_LAST) begin
          state_d     = S_TALLY;
          tally_start = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_TALLY:  if (tally_last) state_d = S_ARGMAX;
      S_ARGMAX: if (tally_done) state_d = S_DONE;
      S_DONE: begin
        result_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  ensemble_vote_tally #(
    .NUM_NETS    (NUM_NETS),
    .NUM_CLASSES (NUM_CLASSES),
    .ID_W        (ID_W)
  ) u_tally (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (enter_stream),
    .start_i      (tally_start),
    .captured_i   (captured_q),
    .winners_i    (winner_q),
    .tally_last_o (tally_last),
    .done_o       (tally_done),
    .class_o      (final_class),
    .votes_o      (final_votes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      wait_q      <= '0;
      captured_q  <= '0;
      winner_q    <= '0;
      timeout_q   <= 1'b0;
      bin_cnt_q   <= '0;
      res_class_q <= '0;
      res_votes_q <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      captured_q <= captured_d;
      winner_q   <= winner_d;
      timeout_q  <= timeout_d;
      bin_cnt_q  <= bin_cnt_d;
      if (tally_done) begin
        res_class_q <= final_class;
        res_votes_q <= final_votes;
        res_to_q    <= timeout_q;
      end
    end
  end

  assign net_bin_cnt    = bin_cnt_q;
  assign result_class   = res_class_q;
  assign result_votes   = res_votes_q;
  assign result_timeout = res_to_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ensemble_infer_scheduler.sv
// Directed bench: main instance (long watchdog) and a short-watchdog instance for the timeout case.
module tb_ensemble_infer_scheduler;
  import ensemble_pkg::*;

  localparam int NN = 20;
  localparam int IDW = 5;
  localparam int CW = 20;
  localparam int VW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           sv_m = 1'b0, sv_t = 1'b0;
  logic           ack_m, ack_t, rd_en_m, rd_en_t;
  logic [9:0]     addr_m, addr_t;
  logic [CW-1:0]  data_m = '0, data_t = '0;
  logic [NN-1:0]  ts_m, ts_t;
  logic [CW-1:0]  cnt_m, cnt_t;
  logic [NN-1:0]  req = '1;
  logic [NN-1:0]  rdy = '0;
  logic [NN*IDW-1:0] win = '0;
  logic           rv_m, rv_t, rto_m, rto_t, busy_m, busy_t;
  logic [IDW-1:0] rc_m, rc_t;
  logic [VW-1:0]  rvot_m, rvot_t;
  state_e         st_m, st_t;

  ensemble_infer_scheduler dut (
    .clk(clk), .rst(rst), .sample_valid(sv_m), .sample_ack(ack_m),
    .mem_rd_en(rd_en_m), .mem_rd_addr(addr_m), .mem_rd_data(data_m),
    .net_trans_start(ts_m), .net_bin_cnt(cnt_m),
    .net_request_new_sample(req), .net_infer_ready(rdy), .net_winner_ID(win),
    .result_valid(rv_m), .result_class(rc_m), .result_votes(rvot_m),
    .result_timeout(rto_m), .busy(busy_m), .dbg_state(st_m)
  );

  ensemble_infer_scheduler #(.WAIT_TIMEOUT(100)) dut_to (
    .clk(clk), .rst(rst), .sample_valid(sv_t), .sample_ack(ack_t),
    .mem_rd_en(rd_en_t), .mem_rd_addr(addr_t), .mem_rd_data(data_t),
    .net_trans_start(ts_t), .net_bin_cnt(cnt_t),
    .net_request_new_sample(req), .net_infer_ready(rdy), .net_winner_ID(win),
    .result_valid(rv_t), .result_class(rc_t), .result_votes(rvot_t),
    .result_timeout(rto_t), .busy(busy_t), .dbg_state(st_t)
  );

  // Sample buffer holds data[i] = i, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_m) data_m <= {{(CW-10){1'b0}}, addr_m};
    if (rd_en_t) data_t <= {{(CW-10){1'b0}}, addr_t};
  end

  logic sel_to = 1'b0;
  logic           o_busy, o_ack, o_rd_en, o_rv, o_rto;
  logic [9:0]     o_addr;
  logic [NN-1:0]  o_ts;
  logic [CW-1:0]  o_cnt;
  logic [IDW-1:0] o_rc;
  logic [VW-1:0]  o_rvot;
  assign o_busy  = sel_to ? busy_t  : busy_m;
  assign o_ack   = sel_to ? ack_t   : ack_m;
  assign o_rd_en = sel_to ? rd_en_t : rd_en_m;
  assign o_rv    = sel_to ? rv_t    : rv_m;
  assign o_rto   = sel_to ? rto_t   : rto_m;
  assign o_addr  = sel_to ? addr_t  : addr_m;
  assign o_ts    = sel_to ? ts_t    : ts_m;
  assign o_cnt   = sel_to ? cnt_t   : cnt_m;
  assign o_rc    = sel_to ? rc_t    : rc_m;
  assign o_rvot  = sel_to ? rvot_t  : rvot_m;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur     = "reset";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d expected %0d", cur, tag, got, exp);
    end
  endtask

  task automatic set_all_winners(input logic [IDW-1:0] id);
    for (int j = 0; j < NN; j++) win[j*IDW +: IDW] = id;
  endtask

  int r_pre, r_start_n, r_start_k, r_start_cnt, r_mid_cnt, r_last_cnt;
  int r_rd_n, r_addr_err, r_ack_n, r_ack_k, r_res_n, r_res_k;
  logic [NN-1:0]  r_start_val;
  logic [IDW-1:0] r_class;
  logic [VW-1:0]  r_votes;
  logic           r_to;

  // Starts a sample, pulses net_infer_ready=mask for one cycle rdy_delay cycles
  // after the ack, and records what the selected instance did (n = STREAM k).
  task automatic run_txn(input logic [NN-1:0] mask, input int rdy_delay);
    int n;
    int ack_at;
    r_pre = 0; r_start_n = 0; r_start_k = -1; r_start_cnt = -1; r_mid_cnt = -1;
    r_last_cnt = -1; r_rd_n = 0; r_addr_err = 0; r_ack_n = 0; r_ack_k = -1;
    r_res_n = 0; r_res_k = -1; r_start_val = '0; r_class = '0; r_votes = '0; r_to = 1'b0;
    n = -1;
    ack_at = -1;
    if (sel_to) sv_t = 1'b1; else sv_m = 1'b1;
    for (int c = 0; c < 3000 && r_res_k < 0; c++) begin
      @(negedge clk);
      rdy = '0;
      if (n < 0) begin
        if (o_busy) n = 0; else r_pre++;
      end else begin
        n++;
      end
      if (n >= 0) begin
        if (o_ts != '0) begin
          r_start_n++; r_start_k = n; r_start_val = o_ts; r_start_cnt = int'(o_cnt);
        end
        if (n == 502)  r_mid_cnt  = int'(o_cnt);
        if (n == 1025) r_last_cnt = int'(o_cnt);
        if (o_rd_en) begin
          r_rd_n++;
          if (int'(o_addr) != n) r_addr_err++;
        end
        if (o_ack) begin
          r_ack_n++; r_ack_k = n; ack_at = n; sv_m = 1'b0; sv_t = 1'b0;
        end
        if (ack_at >= 0 && n == ack_at + rdy_delay) rdy = mask;
        if (o_rv) begin
          r_res_n++; r_res_k = n; r_class = o_rc; r_votes = o_rvot; r_to = o_rto;
        end
      end
    end
    sv_m = 1'b0;
    sv_t = 1'b0;
  endtask

  task automatic check_run(input int exp_k, input int cls, input int votes, input int to);
    check_eq("pre_cycles", r_pre, 0);
    check_eq("start_pulses", r_start_n, 1);
    check_eq("start_k", r_start_k, 2);
    check_eq("start_mask", r_start_val, {NN{1'b1}});
    check_eq("bin_at_start", r_start_cnt, 0);
    check_eq("bin_at_502", r_mid_cnt, 500);
    check_eq("bin_at_1025", r_last_cnt, 1023);
    check_eq("rd_en_cycles", r_rd_n, 1024);
    check_eq("addr_errors", r_addr_err, 0);
    check_eq("ack_count", r_ack_n, 1);
    check_eq("ack_k", r_ack_k, 1025);
    check_eq("result_count", r_res_n, 1);
    check_eq("result_k", r_res_k, exp_k);
    check_eq("class", r_class, cls);
    check_eq("votes", r_votes, votes);
    check_eq("timeout", r_to, to);
    @(negedge clk);
    check_eq("busy_after", o_busy, 0);
    check_eq("class_held", o_rc, cls);
    check_eq("votes_held", o_rvot, votes);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("busy_m", busy_m, 0);
    check_eq("busy_t", busy_t, 0);
    check_eq("state_m", st_m, S_IDLE);
    check_eq("rd_en", rd_en_m, 0);
    check_eq("ack", ack_m, 0);
    check_eq("trans_start", ts_m, 0);
    check_eq("result_valid", rv_m, 0);
    check_eq("bin_cnt", cnt_m, 0);
    check_eq("result_class", rc_m, 0);
    check_eq("result_votes", rvot_m, 0);
    check_eq("result_timeout", rto_m, 0);
    rst = 1'b0;
    @(negedge clk);

    // All nets answer 7, 500 cycles after the ack: W = 501.
    cur = "all_seven";
    set_all_winners(5'd7);
    run_txn({NN{1'b1}}, 500);
    check_run(1026 + 501 + 38, 7, 20, 0);

    // 8x5 on low nets, 8x3, 4x11: tie goes to the lower class.
    cur = "tie_split";
    for (int j = 0; j < NN; j++) win[j*IDW +: IDW] = (j < 8) ? 5'd5 : (j < 16) ? 5'd3 : 5'd11;
    run_txn({NN{1'b1}}, 0);
    check_run(1026 + 1 + 38, 3, 8, 0);

    // Nets 0-2 never answer; short watchdog runs out after exactly 100 WAIT cycles.
    cur = "timeout";
    sel_to = 1'b1;
    set_all_winners(5'd6);
    for (int j = 0; j < 3; j++) win[j*IDW +: IDW] = 5'd1;
    run_txn(~{{(NN-3){1'b0}}, 3'b111}, 10);
    check_run(1026 + 100 + 38, 6, 17, 1);
    sel_to = 1'b0;

    // Net 4 reports an out-of-range ID.
    cur = "bad_id";
    set_all_winners(5'd2);
    win[4*IDW +: IDW] = 5'd25;
    run_txn({NN{1'b1}}, 7);
    check_run(1026 + 8 + 38, 2, 19, 0);

    // Net 9 not requesting: sample must wait in IDLE.
    cur = "blocked";
    set_all_winners(5'd9);
    req[9] = 1'b0;
    sv_m = 1'b1;
    begin
      int busy_seen;
      int rd_seen;
      busy_seen = 0;
      rd_seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (busy_m) busy_seen++;
        if (rd_en_m) rd_seen++;
      end
      check_eq("busy_while_blocked", busy_seen, 0);
      check_eq("rd_while_blocked", rd_seen, 0);
    end
    req[9] = 1'b1;
    run_txn({NN{1'b1}}, 0);
    check_run(1026 + 1 + 38, 9, 20, 0);

    // Reset at STREAM k=300, then a clean sample.
    cur = "abort";
    set_all_winners(5'd13);
    sv_m = 1'b1;
    begin
      int n;
      int acks;
      n = -1;
      acks = 0;
      for (int c = 0; c < 320 && n < 300; c++) begin
        @(negedge clk);
        if (n < 0) begin
          if (busy_m) n = 0;
        end else begin
          n++;
        end
        if (ack_m) acks++;
      end
      check_eq("reached_k300", n, 300);
      check_eq("acks_before_rst", acks, 0);
    end
    rst = 1'b1;
    sv_m = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy_m, 0);
    check_eq("rst_state", st_m, S_IDLE);
    check_eq("rst_rd_en", rd_en_m, 0);
    check_eq("rst_addr", addr_m, 0);
    check_eq("rst_ack", ack_m, 0);
    check_eq("rst_ts", ts_m, 0);
    check_eq("rst_rv", rv_m, 0);
    check_eq("rst_bin_cnt", cnt_m, 0);
    check_eq("rst_class", rc_m, 0);
    check_eq("rst_votes", rvot_m, 0);
    rst = 1'b0;
    @(negedge clk);
    cur = "after_abort";
    run_txn({NN{1'b1}}, 3);
    check_run(1026 + 4 + 38, 13, 20, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ensemble_infer_scheduler.md
# ensemble_infer_scheduler

Top-level scheduler for the bin-ratio ensemble. It takes one 1024-bin spectrum from the host sample buffer and broadcasts it to NUM_NETS bin-ratio spiking network instances, one per diagonal. It then collects each instance's winner ID and returns a majority-vote class to the host. It owns the sample-buffer read port, the per-net start pulses, a completion watchdog and the sequential vote.

## Interface
Parameters:
- NUM_NETS, 20, number of network instances (diagonals 0..NUM_NETS-1)
- NUM_CLASSES, 18, valid winner IDs 0..NUM_CLASSES-1
- BIN_NUM, 1024, bins per sample
- CNT_W, 20, bin count width
- ID_W, 5, winner ID width
- WAIT_TIMEOUT, 60000, maximum cycles in WAIT (16-bit counter)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- sample_valid  in  1  host buffer holds a full sample; held until sample_ack
- sample_ack  out  1  one-cycle pulse; buffer may be overwritten
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  10  bin address
- mem_rd_data  in  CNT_W  read data, 1-cycle latency
- net_trans_start  out  NUM_NETS  per-net start pulse (all bits pulse together)
- net_bin_cnt  out  CNT_W  registered bin count, broadcast to all nets
- net_request_new_sample  in  NUM_NETS  net idle and able to accept a sample
- net_infer_ready  in  NUM_NETS  net inference complete (pulse or level)
- net_winner_ID  in  NUM_NETS*ID_W  net j occupies bits [j*ID_W +: ID_W]
- result_valid  out  1  one-cycle pulse
- result_class  out  ID_W  voted class
- result_votes  out  clog2(NUM_NETS+1)  votes for result_class
- result_timeout  out  1  at least one net excluded from the vote
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE → STREAM → WAIT → TALLY → ARGMAX → DONE → IDLE.
- IDLE: go to STREAM when sample_valid=1 and all net_request_new_sample bits are 1. Otherwise stay in IDLE.
- On entry to STREAM, clear the captured[] bits, the vote counters, the timeout counter and the best register.
- STREAM lasts BIN_NUM+2 cycles, indexed k=0..BIN_NUM+1:
  - mem_rd_en=1 and mem_rd_addr=k for k<BIN_NUM.
  - net_bin_cnt is loaded from mem_rd_data, so bin i appears at cycle i+2.
  - net_trans_start is all-ones at k=2 only, coincident with bin 0.
  - sample_ack pulses at k=BIN_NUM+1.
- Completion capture is armed from STREAM entry onward. Each cycle, for each net j with net_infer_ready[j]=1 and captured[j]=0: set captured[j] and latch winner[j]. The first capture is final.
- WAIT:
  - Go to TALLY when all captured bits are 1.
  - Otherwise go to TALLY when the timeout counter reaches WAIT_TIMEOUT-1, and set the timeout flag.
- TALLY: NUM_NETS cycles, one net per cycle, in index order. Increment vote[winner[j]] only if captured[j]=1 and winner[j]<NUM_CLASSES. Out-of-range IDs are dropped and do not set the timeout flag.
- ARGMAX: NUM_CLASSES cycles, class c=0 upward. Replace best only when vote[c] > best_votes (strictly greater), so ties resolve to the lowest class.
- DONE: one cycle. result_valid=1; result_class, result_votes and result_timeout hold the final values. Then return to IDLE.
- If no net contributes a vote, the result is class 0 with 0 votes.
- Vote counters are clog2(NUM_NETS+1) bits wide and cannot overflow.

## Timing
- Reset values: sample_ack, mem_rd_en, net_trans_start, result_valid and busy are 0. mem_rd_addr, net_bin_cnt, result_class, result_votes and result_timeout are 0. State is IDLE.
- Latency with no timeout, from the IDLE→STREAM edge to result_valid: (BIN_NUM+2) + W + NUM_NETS + NUM_CLASSES cycles, where W is the number of WAIT cycles (at least 1).
- rst asserted in any state: return to IDLE on the next edge. No start pulse, ack or result is emitted. Captures are discarded.
- sample_valid deasserted during STREAM: ignored. The host contract is to hold the sample until ack.
- result_class, result_votes and result_timeout hold their values until the next DONE.
- A new sample cannot start before the return to IDLE, so at most one sample is in flight.

## Structure
- Shared package ensemble_pkg: BIN_NUM, CNT_W, ID_W, NUM_CLASSES, and the state encoding (IDLE/STREAM/WAIT/TALLY/ARGMAX/DONE).
- Sub-module ensemble_vote_tally: holds the vote counters and performs TALLY and ARGMAX (start/done handshake, returns class/votes). The scheduler keeps the FSM, streaming, capture and watchdog.

## Test plan
- Single sample with buffer data[i]=i; all nets ready 500 cycles after ack, winners all 7 → trans_start at STREAM k=2 with net_bin_cnt=0 and net_bin_cnt=1023 at k=1025. Result: class 7, votes 20, timeout 0.
- Winners split 8×3, 8×5, 4×11 → class 3, votes 8 (tie broken to the lower class).
- Nets 0–2 never ready, WAIT_TIMEOUT=100 → DONE after exactly 100 WAIT cycles; timeout=1; votes counted from 17 nets only.
- Net 4 reports ID 25 and the rest report 2 → class 2, votes 19, timeout 0.
- net_request_new_sample[9]=0 while sample_valid=1 → stays in IDLE with no mem_rd_en. Release bit 9 → STREAM begins on the next edge.
- rst pulsed at STREAM k=300 → next cycle is IDLE with all outputs 0. A fresh sample afterwards completes normally with no sample_ack from the aborted run.
